// File: rtl/control_fifo_pkg.sv
// Shared constants, serializer state encoding and sizing helper for the
// control FIFO family.
package control_fifo_pkg;

  localparam int WORD_W         = 256;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Pointer width for a FIFO of the given depth; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/word_fifo_sync.sv
// Single-clock register FIFO of DEPTH words with registered level/full/empty.
// Level and flags are registered from the next-level value so they agree.
module word_fifo_sync
  import control_fifo_pkg::*;
#(
  parameter int W     = 256,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr,
  input  logic                     i_rd,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic [ptr_w(DEPTH):0]    o_level,
  output logic [ptr_w(DEPTH):0]    o_level_next,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_full;
  logic          r_empty;
  logic          w_wr;
  logic          w_rd;
  logic [LW-1:0] w_level_next;

  // A write while full is dropped even if a read frees a slot this cycle.
  assign w_wr = i_wr & ~r_full;
  assign w_rd = i_rd & ~r_empty;

  always_comb begin
    w_level_next = r_level;
    case ({w_wr, w_rd})
      2'b10:   w_level_next = r_level + 1'b1;
      2'b01:   w_level_next = r_level - 1'b1;
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_next;
      r_full  <= (w_level_next == FULL_LVL);
      r_empty <= (w_level_next == '0);
    end
  end

  assign o_dout       = r_mem[r_rd_ptr];
  assign o_level      = r_level;
  assign o_level_next = w_level_next;
  assign o_full       = r_full;
  assign o_empty      = r_empty;

endmodule

// File: rtl/control_unpack_fifo.sv
// Buffers wide datapath words and serializes each into bytes on a
// valid/ready stream, reloading back-to-back without a bubble.
module control_unpack_fifo
  import control_fifo_pkg::*;
#(
  parameter int WORD_W   = control_fifo_pkg::WORD_W,
  parameter int BYTE_W   = control_fifo_pkg::BYTE_W,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wrreq,
  input  logic [WORD_W-1:0]         din,
  output logic                      full,
  output logic                      almost_full,
  output logic [$clog2(DEPTH):0]    wr_water_level,
  output logic                      overflow,
  output logic [BYTE_W-1:0]         dout,
  output logic                      dout_valid,
  input  logic                      ready,
  output logic                      last,
  output logic                      empty,
  output logic                      almost_empty
);

  localparam int NB = WORD_W / BYTE_W;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW = ptr_w(DEPTH) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);
  localparam logic [LW-1:0] AF_LVL   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_LVL   = LW'(AE_LEVEL);

  state_t              r_state;
  state_t              w_state_next;
  logic [WORD_W-1:0]   r_shift;
  logic [CW-1:0]       r_byte_cnt;
  logic                r_dout_valid;
  logic                r_overflow;
  logic                r_almost_full;
  logic                r_almost_empty;
  logic                r_empty;
  logic                w_pop;
  logic                w_handshake;
  logic                w_last_byte;
  logic [WORD_W-1:0]   w_fifo_dout;
  logic [LW-1:0]       w_level;
  logic [LW-1:0]       w_level_next;
  logic                w_fifo_full;
  logic                w_fifo_empty;

  word_fifo_sync #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_word_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wr         (wrreq),
    .i_rd         (w_pop),
    .i_din        (din),
    .o_dout       (w_fifo_dout),
    .o_level      (w_level),
    .o_level_next (w_level_next),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty)
  );

  assign w_handshake = r_dout_valid & ready;
  assign w_last_byte = w_handshake && (r_byte_cnt == LAST_IDX);

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        // Reload on the final byte's edge so consecutive words have no gap.
        if (w_last_byte) begin
          if (!w_fifo_empty) w_pop = 1'b1;
          else               w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_shift        <= '0;
      r_byte_cnt     <= '0;
      r_dout_valid   <= 1'b0;
      r_overflow     <= 1'b0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_empty        <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_pop)            r_shift <= w_fifo_dout;
      else if (w_handshake) r_shift <= r_shift >> BYTE_W;
      if (w_pop || w_last_byte) r_byte_cnt <= '0;
      else if (w_handshake)     r_byte_cnt <= r_byte_cnt + 1'b1;
      r_dout_valid   <= (w_state_next == SHIFT);
      r_overflow     <= wrreq & w_fifo_full;
      r_almost_full  <= (w_level_next >= AF_LVL);
      r_almost_empty <= (w_level_next <= AE_LVL);
      r_empty        <= (w_level_next == '0) && (w_state_next == IDLE);
    end
  end

  assign full           = w_fifo_full;
  assign almost_full    = r_almost_full;
  assign wr_water_level = w_level;
  assign overflow       = r_overflow;
  assign dout           = r_shift[BYTE_W-1:0];
  assign dout_valid     = r_dout_valid;
  assign last           = r_dout_valid && (r_byte_cnt == LAST_IDX);
  assign empty          = r_empty;
  assign almost_empty   = r_almost_empty;

endmodule

// File: tb/tb_control_unpack_fifo.sv
// Directed bench for control_unpack_fifo: latency, fill/overflow, streaming,
// backpressure, concurrent write/reload and mid-word reset.
module tb_control_unpack_fifo;

  logic         clk;
  logic         rst_n;
  logic         wrreq;
  logic [255:0] din;
  logic         full;
  logic         almost_full;
  logic [3:0]   wr_water_level;
  logic         overflow;
  logic [7:0]   dout;
  logic         dout_valid;
  logic         ready;
  logic         last;
  logic         empty;
  logic         almost_empty;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q [$];

  control_unpack_fifo dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wrreq          (wrreq),
    .din            (din),
    .full           (full),
    .almost_full    (almost_full),
    .wr_water_level (wr_water_level),
    .overflow       (overflow),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .ready          (ready),
    .last           (last),
    .empty          (empty),
    .almost_empty   (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Word whose byte k equals seed + k.
  function automatic logic [255:0] mk(input logic [7:0] seed);
    logic [255:0] w;
    for (int k = 0; k < 32; k++) w[k*8 +: 8] = seed + 8'(k);
    return w;
  endfunction

  task automatic push_word(input logic [255:0] w);
    for (int k = 0; k < 32; k++) exp_q.push_back(w[k*8 +: 8]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consume n bytes against the expected queue; every valid cycle is checked,
  // so held bytes under backpressure are checked repeatedly.
  task automatic drain(input string tag, input int n, input int bound,
                       input bit rnd, output int gaps);
    int got;
    int cyc;
    got  = 0;
    cyc  = 0;
    gaps = 0;
    while (got < n && cyc < bound) begin
      ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      if (dout_valid) begin
        chk({tag, "_byte"}, {56'd0, dout}, {56'd0, exp_q.size() > 0 ? exp_q[0] : 8'hxx});
        chk({tag, "_last"}, {63'd0, last}, {63'd0, (got % 32) == 31});
        if (ready) begin
          void'(exp_q.pop_front());
          got++;
        end
      end else begin
        gaps++;
      end
      tick();
      cyc++;
    end
    chk({tag, "_count"}, 64'(got), 64'(n));
  endtask

  initial begin
    int gaps;
    int stale;
    int lvl;
    logic [255:0] w;

    rst_n = 1'b0;
    wrreq = 1'b0;
    din   = '0;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    chk("rst_full",   {63'd0, full},        64'd0);
    chk("rst_af",     {63'd0, almost_full}, 64'd0);
    chk("rst_level",  {60'd0, wr_water_level}, 64'd0);
    chk("rst_ovf",    {63'd0, overflow},    64'd0);
    chk("rst_dout",   {56'd0, dout},        64'd0);
    chk("rst_valid",  {63'd0, dout_valid},  64'd0);
    chk("rst_last",   {63'd0, last},        64'd0);
    chk("rst_empty",  {63'd0, empty},       64'd1);
    chk("rst_ae",     {63'd0, almost_empty}, 64'd1);
    rst_n = 1'b1;
    tick();

    // Single word, one-cycle load latency, bytes 0x00..0x1F
    ready = 1'b1;
    wrreq = 1'b1;
    din   = mk(8'h00);
    tick();
    wrreq = 1'b0;
    chk("t1_level_after_wr", {60'd0, wr_water_level}, 64'd1);
    chk("t1_valid_after_wr", {63'd0, dout_valid}, 64'd0);
    chk("t1_empty_after_wr", {63'd0, empty}, 64'd0);
    tick();
    chk("t1_level_after_load", {60'd0, wr_water_level}, 64'd0);
    for (int k = 0; k < 32; k++) begin
      chk("t1_valid", {63'd0, dout_valid}, 64'd1);
      chk("t1_dout",  {56'd0, dout}, 64'(k));
      chk("t1_last",  {63'd0, last}, {63'd0, k == 31});
      tick();
    end
    chk("t1_valid_end", {63'd0, dout_valid}, 64'd0);
    chk("t1_empty_end", {63'd0, empty}, 64'd1);

    // Fill with ready=0: first word to serializer, then level 1..8, overflow
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wrreq = 1'b1;
      din   = mk(8'(i * 32));
      if (i < 9) push_word(din);
      tick();
      lvl = (i == 0) ? 1 : ((i < 9) ? i : 8);
      chk("t2_level", {60'd0, wr_water_level}, 64'(lvl));
      chk("t2_full",  {63'd0, full},         {63'd0, lvl == 8});
      chk("t2_af",    {63'd0, almost_full},  {63'd0, lvl >= 6});
      chk("t2_ae",    {63'd0, almost_empty}, {63'd0, lvl <= 1});
      chk("t2_ovf",   {63'd0, overflow},     {63'd0, i == 9});
    end
    wrreq = 1'b0;
    tick();
    chk("t2_ovf_clear",  {63'd0, overflow}, 64'd0);
    chk("t2_level_hold", {60'd0, wr_water_level}, 64'd8);
    chk("t2_held_byte",  {56'd0, dout}, 64'h00);
    drain("t2", 288, 400, 1'b0, gaps);
    chk("t2_gaps", 64'(gaps), 64'd0);
    chk("t2_empty", {63'd0, empty}, 64'd1);

    // Eight random words streamed at full rate: 256 bytes, no bubbles
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) w[j*32 +: 32] = $urandom;
      wrreq = 1'b1;
      din   = w;
      push_word(w);
      tick();
    end
    wrreq = 1'b0;
    chk("t3_level", {60'd0, wr_water_level}, 64'd7);
    drain("t3", 256, 300, 1'b0, gaps);
    chk("t3_gaps", 64'(gaps), 64'd0);
    chk("t3_valid_end", {63'd0, dout_valid}, 64'd0);
    chk("t3_empty", {63'd0, empty}, 64'd1);

    // Random backpressure
    ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wrreq = 1'b1;
      din   = mk(8'(8'hA0 + i * 8'h40));
      push_word(din);
      tick();
    end
    wrreq = 1'b0;
    drain("t4", 64, 1000, 1'b1, gaps);
    ready = 1'b1;
    tick();
    chk("t4_empty", {63'd0, empty}, 64'd1);

    // Concurrent write and final-byte reload at level 3
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wrreq = 1'b1;
      din   = mk(8'(8'h10 + i * 8'h40));
      tick();
    end
    wrreq = 1'b0;
    chk("t5_level_setup", {60'd0, wr_water_level}, 64'd3);
    chk("t5_a_byte0", {56'd0, dout}, 64'h10);
    ready = 1'b1;
    repeat (31) tick();
    chk("t5_a_byte31", {56'd0, dout}, 64'h2F);
    chk("t5_a_last",   {63'd0, last}, 64'd1);
    wrreq = 1'b1;
    din   = mk(8'h30);
    tick();
    wrreq = 1'b0;
    chk("t5_level_same", {60'd0, wr_water_level}, 64'd3);
    chk("t5_b_byte0",    {56'd0, dout}, 64'h50);
    chk("t5_b_valid",    {63'd0, dout_valid}, 64'd1);
    chk("t5_b_last",     {63'd0, last}, 64'd0);

    // Reset at byte 10 of the current word
    repeat (10) tick();
    chk("t6_byte10", {56'd0, dout}, 64'h5A);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_rst", {63'd0, dout_valid}, 64'd0);
    chk("t6_empty_rst", {63'd0, empty}, 64'd1);
    chk("t6_level_rst", {60'd0, wr_water_level}, 64'd0);
    chk("t6_dout_rst",  {56'd0, dout}, 64'd0);
    tick();
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (dout_valid) stale++;
    end
    chk("t6_stale", 64'(stale), 64'd0);
    chk("t6_empty_idle", {63'd0, empty}, 64'd1);
    wrreq = 1'b1;
    din   = mk(8'h77);
    push_word(din);
    tick();
    wrreq = 1'b0;
    chk("t6_valid_wr", {63'd0, dout_valid}, 64'd0);
    tick();
    chk("t6_new_byte0", {56'd0, dout}, 64'h77);
    drain("t6", 32, 100, 1'b0, gaps);
    chk("t6_empty_end", {63'd0, empty}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
